enemy_control: RTL and testbench
================================

Name: enemy_control

Overview:
- Per-frame sequencer for the enemy sprite movers, upstream of each enemy instance.
- Generates their state strobes: init, idle, gen_move, apply_move, draw.
- Time-multiplexes NUM_ENEMIES enemies onto one VGA write path, erasing the play area first each frame.
- Consumes the selected enemy's draw_done and the background renderer's bg_done.

Parameters:
- NUM_ENEMIES, 4: number of enemy instances sequenced per frame (1..8).
- FRAME_CYCLES, 833333: clock cycles per game frame (60 Hz at 50 MHz).
- COLL_WAIT, 2: cycles held in CHECK for collision_detector to settle (>=1).
- DRAW_TIMEOUT, 1023: maximum cycles allowed in DRAW or ERASE before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  level; game running enable
- bg_done  in  1  one-cycle pulse from background renderer, erase complete
- draw_done  in  1  one-cycle pulse from currently selected enemy
- enemy_sel  out  3  index of enemy currently owning the strobes and VGA path
- init  out  1  to all enemies
- idle  out  1  to all enemies
- gen_move  out  1  to selected enemy only (qualified by enemy_sel externally)
- apply_move  out  1  to selected enemy only
- draw  out  1  to selected enemy only
- bg_draw  out  1  background renderer enable
- frame_tick  out  1  one-cycle pulse at frame boundary
- overrun  out  1  sticky; frame_tick arrived while not in IDLE
- timeout_err  out  1  sticky; DRAW/ERASE exceeded DRAW_TIMEOUT

Behaviour:
- States: RST, INIT, IDLE, ERASE, GEN, CHECK, APPLY, DRAW.
- Strobes are a registered one-hot decode of the state:
  - INIT->init, IDLE->idle, ERASE->bg_draw, GEN->gen_move, APPLY->apply_move, DRAW->draw.
  - RST asserts none.
- Reset: state=RST, enemy_sel=0, all strobes 0, frame counter=0, wait/timeout counters=0, overrun=0, timeout_err=0.
- Frame counter:
  - Free-running from reset: 0..FRAME_CYCLES-1, then wraps to 0.
  - frame_tick=1 for the cycle in which the counter==FRAME_CYCLES-1.
- Transitions:
  - RST->INIT when start=1; otherwise stays in RST.
  - INIT lasts exactly 1 cycle, then ->IDLE.
  - IDLE->ERASE on frame_tick when start=1. If start=0 in IDLE, ->RST.
  - ERASE->GEN on bg_done. enemy_sel=0 on entry to GEN from ERASE.
  - GEN lasts 1 cycle, then ->CHECK.
  - CHECK lasts exactly COLL_WAIT cycles, then ->APPLY.
  - APPLY lasts 1 cycle, then ->DRAW.
  - DRAW->next on draw_done:
    - if enemy_sel<NUM_ENEMIES-1: enemy_sel+=1 and ->GEN;
    - else: enemy_sel=0 and ->IDLE.
- Timeout:
  - Counter clears on entry to ERASE or DRAW and increments each cycle there.
  - On reaching DRAW_TIMEOUT without the done pulse: set timeout_err.
  - From DRAW: treat as draw_done and advance.
  - From ERASE: go to GEN.
- Overrun: frame_tick in any state other than IDLE/RST/INIT sets overrun. The tick is dropped, not queued.
- Done pulses outside their owning state (bg_done outside ERASE, draw_done outside DRAW) are ignored.
- draw_done and timeout in the same cycle: advance once; timeout_err is still set.
- start deasserted mid-frame: the current frame completes; return to RST from IDLE.
- Reset mid-operation takes priority over everything and returns to the reset values above.
- Latency, frame_tick to first gen_move (bg_done assumed on the 1st ERASE cycle): 3 cycles.
- Per-enemy overhead excluding draw: 2+COLL_WAIT cycles.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants (RST..DRAW, 3-bit);
  - the direction codes NO_ACTION/ATTACK/UP/DOWN/LEFT/RIGHT (already used by the enemy and link movers);
  - ON/OFF.
- One natural sub-module: frame_timer, the frame counter plus frame_tick generation, parameterised by FRAME_CYCLES.
- The watchdog counter stays inline.

Test Plan:
- Reset, start=1, FRAME_CYCLES=16: init high exactly 1 cycle, then idle. frame_tick is first seen at cycle 15 after reset release (counter hits 15), then every 16 cycles.
- NUM_ENEMIES=3, bg_done 2 cycles into ERASE, draw_done 5 cycles into each DRAW:
  - enemy_sel steps 0,1,2;
  - exactly 3 gen_move, 3 apply_move and 3 draw bursts;
  - each CHECK is COLL_WAIT=2 cycles;
  - returns to IDLE with enemy_sel=0.
- draw_done never pulsed, DRAW_TIMEOUT=8: DRAW lasts 8 cycles, timeout_err=1 and stays 1, the FSM advances to the next enemy.
- FRAME_CYCLES=16, draw_done held off 20 cycles: a frame_tick lands during DRAW, so overrun=1. The next ERASE starts only on a later frame_tick seen in IDLE.
- Spurious draw_done in IDLE and spurious bg_done in DRAW: no state change, enemy_sel unchanged.
- Reset asserted for 1 cycle while in CHECK with enemy_sel=2: next cycle state=RST, enemy_sel=0, all strobes 0, sticky flags cleared.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: sequencer state encoding, mover direction codes, ON/OFF.
// Also holds the registered strobe bundle type and the state-to-strobe decode.
package game_pkg;

    localparam logic [2:0] RST   = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;
    localparam logic [2:0] IDLE  = 3'd2;
    localparam logic [2:0] ERASE = 3'd3;
    localparam logic [2:0] GEN   = 3'd4;
    localparam logic [2:0] CHECK = 3'd5;
    localparam logic [2:0] APPLY = 3'd6;
    localparam logic [2:0] DRAW  = 3'd7;

    localparam logic [2:0] NO_ACTION = 3'd0;
    localparam logic [2:0] ATTACK    = 3'd1;
    localparam logic [2:0] UP        = 3'd2;
    localparam logic [2:0] DOWN      = 3'd3;
    localparam logic [2:0] LEFT      = 3'd4;
    localparam logic [2:0] RIGHT     = 3'd5;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef struct packed {
        logic init;
        logic idle;
        logic bg_draw;
        logic gen_move;
        logic apply_move;
        logic draw;
    } strobe_t;

    function automatic strobe_t state_strobes(input logic [2:0] st);
        strobe_t s;
        s = '0;
        case (st)
            INIT:    s.init       = ON;
            IDLE:    s.idle       = ON;
            ERASE:   s.bg_draw    = ON;
            GEN:     s.gen_move   = ON;
            APPLY:   s.apply_move = ON;
            DRAW:    s.draw       = ON;
            default: s            = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame counter 0..FRAME_CYCLES-1; frame_tick_o marks the last count.
// No backpressure: the tick is a plain decode of the counter register.
module frame_timer #(
    parameter int FRAME_CYCLES = 833333
) (
    input  logic clock,
    input  logic reset,
    output logic frame_tick_o
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/enemy_control.sv
// Per-frame sequencer: erase the play area, then GEN/CHECK/APPLY/DRAW each enemy in turn.
// Strobes and enemy_sel are registered one cycle behind the state; done pulses or a watchdog advance it.
module enemy_control
    import game_pkg::*;
#(
    parameter int NUM_ENEMIES  = 4,
    parameter int FRAME_CYCLES = 833333,
    parameter int COLL_WAIT    = 2,
    parameter int DRAW_TIMEOUT = 1023
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       bg_done,
    input  logic       draw_done,
    output logic [2:0] enemy_sel,
    output logic       init,
    output logic       idle,
    output logic       gen_move,
    output logic       apply_move,
    output logic       draw,
    output logic       bg_draw,
    output logic       frame_tick,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int CWW = $clog2(COLL_WAIT + 1);
    localparam int WDW = $clog2(DRAW_TIMEOUT + 1);
    localparam logic [CWW-1:0] COLL_LAST = CWW'(COLL_WAIT - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(DRAW_TIMEOUT - 1);
    localparam logic [2:0]     SEL_LAST  = 3'(NUM_ENEMIES - 1);

    logic [2:0]     state_q, state_d;
    logic [2:0]     sel_q, sel_d;
    logic [CWW-1:0] wait_q, wait_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           overrun_q, overrun_d;
    logic           tmo_q, tmo_d;
    logic [2:0]     sel_out_q;
    strobe_t        strb_q;
    logic           wd_hit;

    frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clock       (clock),
        .reset       (reset),
        .frame_tick_o(frame_tick)
    );

    assign wd_hit = (wd_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wait_d    = wait_q;
        wd_d      = wd_q;
        overrun_d = overrun_q;
        tmo_d     = tmo_q;

        // A tick outside the quiet states is dropped, not queued.
        if (frame_tick && !(state_q inside {RST, INIT, IDLE})) begin
            overrun_d = ON;
        end

        case (state_q)
            RST: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (!start) begin
                    state_d = RST;
                end else if (frame_tick) begin
                    state_d = ERASE;
                    wd_d    = '0;
                end
            end
            ERASE: begin
                wd_d = wd_q + WDW'(1);
                if (bg_done || wd_hit) begin
                    if (!bg_done) tmo_d = ON;
                    state_d = GEN;
                    sel_d   = '0;
                end
            end
            GEN: begin
                state_d = CHECK;
                wait_d  = '0;
            end
            CHECK: begin
                if (wait_q == COLL_LAST) begin
                    state_d = APPLY;
                end else begin
                    wait_d = wait_q + CWW'(1);
                end
            end
            APPLY: begin
                state_d = DRAW;
                wd_d    = '0;
            end
            DRAW: begin
                wd_d = wd_q + WDW'(1);
                if (wd_hit) tmo_d = ON;
                if (draw_done || wd_hit) begin
                    if (sel_q < SEL_LAST) begin
                        sel_d   = sel_q + 3'd1;
                        state_d = GEN;
                    end else begin
                        sel_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RST;
            sel_q     <= '0;
            wait_q    <= '0;
            wd_q      <= '0;
            overrun_q <= OFF;
            tmo_q     <= OFF;
            sel_out_q <= '0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wait_q    <= wait_d;
            wd_q      <= wd_d;
            overrun_q <= overrun_d;
            tmo_q     <= tmo_d;
            sel_out_q <= sel_q;
            strb_q    <= state_strobes(state_q);
        end
    end

    assign enemy_sel   = sel_out_q;
    assign init        = strb_q.init;
    assign idle        = strb_q.idle;
    assign bg_draw     = strb_q.bg_draw;
    assign gen_move    = strb_q.gen_move;
    assign apply_move  = strb_q.apply_move;
    assign draw        = strb_q.draw;
    assign overrun     = overrun_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_enemy_control.sv
// Directed bench: a 64-cycle-frame instance for sequencing and a 16-cycle-frame instance
// for tick timing, watchdog and overrun; expectations are hand-derived cycle numbers.
module tb_enemy_control;

    logic       clock = 1'b0;
    logic       reset, start;
    logic       bg_done, draw_done, f_bg_done, f_draw_done;
    logic [2:0] enemy_sel, f_enemy_sel;
    logic       init, idle, gen_move, apply_move, draw, bg_draw, frame_tick, overrun, timeout_err;
    logic       f_init, f_idle, f_gen_move, f_apply_move, f_draw, f_bg_draw;
    logic       f_frame_tick, f_overrun, f_timeout_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int bg_run, bg_w, dr_run, chk_cnt, gen_cnt, apply_cnt, draw_bursts;
    int f_dr_run, f_draw_w, f_bg_rise, f_init_cnt;
    bit in_chk, spur_bg, f_bg_prev;
    logic [2:0] gen_sel [3];

    always #5 clock = ~clock;

    enemy_control #(
        .NUM_ENEMIES(3), .FRAME_CYCLES(64), .COLL_WAIT(2), .DRAW_TIMEOUT(8)
    ) u_dut (
        .clock(clock), .reset(reset), .start(start), .bg_done(bg_done), .draw_done(draw_done),
        .enemy_sel(enemy_sel), .init(init), .idle(idle), .gen_move(gen_move),
        .apply_move(apply_move), .draw(draw), .bg_draw(bg_draw), .frame_tick(frame_tick),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    enemy_control #(
        .NUM_ENEMIES(3), .FRAME_CYCLES(16), .COLL_WAIT(2), .DRAW_TIMEOUT(8)
    ) u_fast (
        .clock(clock), .reset(reset), .start(start), .bg_done(f_bg_done), .draw_done(f_draw_done),
        .enemy_sel(f_enemy_sel), .init(f_init), .idle(f_idle), .gen_move(f_gen_move),
        .apply_move(f_apply_move), .draw(f_draw), .bg_draw(f_bg_draw), .frame_tick(f_frame_tick),
        .overrun(f_overrun), .timeout_err(f_timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_counts();
        gen_cnt = 0; apply_cnt = 0; draw_bursts = 0; bg_w = 0;
        for (int i = 0; i < 3; i++) gen_sel[i] = 3'd7;
    endtask

    // One clock; sample #1 after the edge, then play the enemy/background roles.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        bg_done = 1'b0; draw_done = 1'b0; f_bg_done = 1'b0;
        if (bg_draw) begin
            bg_run++;
            if (bg_run == 1) bg_done = 1'b1;
        end else begin
            if (bg_run != 0) bg_w = bg_run;
            bg_run = 0;
        end
        if (draw) begin
            dr_run++;
            if (dr_run == 5) draw_done = 1'b1;
            if (spur_bg && dr_run == 2) bg_done = 1'b1;
        end else begin
            if (dr_run != 0) begin
                chk("draw_len", 32'(dr_run), 32'd6);
                draw_bursts++;
            end
            dr_run = 0;
        end
        if (gen_move) begin
            if (gen_cnt < 3) gen_sel[gen_cnt] = enemy_sel;
            gen_cnt++; in_chk = 1'b1; chk_cnt = 0;
        end else if (apply_move) begin
            apply_cnt++;
            if (in_chk) chk("check_len", 32'(chk_cnt), 32'd2);
            in_chk = 1'b0;
        end else if (in_chk) begin
            chk_cnt++;
        end
        if (f_draw) f_dr_run++;
        else begin
            if (f_dr_run != 0) f_draw_w = f_dr_run;
            f_dr_run = 0;
        end
        if (f_bg_draw && !f_bg_prev) begin
            f_bg_rise++;
            f_bg_done = 1'b1;
        end
        f_bg_prev = f_bg_draw;
        if (f_init) f_init_cnt++;
    endtask

    task automatic frame_summary(input string tag);
        chk({tag, "_gen"}, 32'(gen_cnt), 32'd3);
        chk({tag, "_apply"}, 32'(apply_cnt), 32'd3);
        chk({tag, "_bursts"}, 32'(draw_bursts), 32'd3);
        chk({tag, "_sel_seq"}, 32'({gen_sel[0], gen_sel[1], gen_sel[2]}), 32'h0A);
        chk({tag, "_erase_len"}, 32'(bg_w), 32'd2);
        chk({tag, "_idle_sel"}, 32'({idle, enemy_sel}), 32'b1000);
        chk({tag, "_flags"}, 32'({overrun, timeout_err}), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        bg_done = 1'b0; draw_done = 1'b0; f_bg_done = 1'b0; f_draw_done = 1'b0;
        cyc = 0; bg_run = 0; dr_run = 0; chk_cnt = 0; in_chk = 1'b0; spur_bg = 1'b0;
        f_dr_run = 0; f_draw_w = 0; f_bg_rise = 0; f_init_cnt = 0; f_bg_prev = 1'b0;
        clear_counts();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_strobes", 32'({init, idle, gen_move, apply_move, draw, bg_draw}), 32'd0);
        chk("rst_sel", 32'(enemy_sel), 32'd0);
        chk("rst_flags", 32'({overrun, timeout_err, frame_tick}), 32'd0);
        chk("f_rst_all", 32'({f_init, f_idle, f_gen_move, f_apply_move, f_draw, f_bg_draw,
                              f_overrun, f_timeout_err, f_frame_tick, f_enemy_sel}), 32'd0);
        reset = 1'b0; start = 1'b1;

        for (int i = 0; i < 230; i++) begin
            step();
            case (cyc)
                1:   chk("init_early", 32'({init, f_init}), 32'd0);
                2:   begin
                         chk("init_on", 32'({init, idle}), 32'b10);
                         chk("f_init_on", 32'({f_init, f_idle}), 32'b10);
                     end
                3:   chk("idle_on", 32'({init, idle}), 32'b01);
                14:  chk("ftick_14", 32'(f_frame_tick), 32'd0);
                15:  chk("ftick_15", 32'(f_frame_tick), 32'd1);
                16:  chk("ftick_16_bg", 32'({f_frame_tick, f_bg_draw}), 32'd0);
                17:  chk("f_erase", 32'(f_bg_draw), 32'd1);
                23:  chk("f_draw0", 32'({f_draw, f_enemy_sel}), 32'b1000);
                29:  chk("f_tmo_pre", 32'(f_timeout_err), 32'd0);
                30:  chk("f_tmo_set", 32'(f_timeout_err), 32'd1);
                31:  begin
                         chk("f_draw_len", 32'(f_draw_w), 32'd8);
                         chk("f_next_enemy", 32'({f_gen_move, f_enemy_sel}), 32'b1001);
                         chk("f_ovr_pre", 32'({f_frame_tick, f_overrun}), 32'b10);
                     end
                32:  chk("f_ovr_set", 32'(f_overrun), 32'd1);
                60:  begin
                         chk("f_init_once", 32'(f_init_cnt), 32'd1);
                         chk("f_sticky", 32'({f_overrun, f_timeout_err, f_idle}), 32'b111);
                     end
                62:  chk("tick_62", 32'(frame_tick), 32'd0);
                63:  chk("tick_63", 32'(frame_tick), 32'd1);
                64:  begin
                         chk("erase_lat", 32'(bg_draw), 32'd0);
                         chk("f_tick_dropped", 32'({f_bg_draw, 3'(f_bg_rise)}), 32'd1);
                     end
                65:  chk("erase_both", 32'({bg_draw, f_bg_draw, 3'(f_bg_rise)}), 32'b11010);
                67:  chk("gen0", 32'({gen_move, enemy_sel}), 32'b1000);
                100: begin frame_summary("fr1"); clear_counts(); end
                105: draw_done = 1'b1;
                110: begin
                         chk("spur_dd_idle", 32'({idle, enemy_sel}), 32'b1000);
                         chk("spur_dd_nogen", 32'(gen_cnt + draw_bursts), 32'd0);
                     end
                120: spur_bg = 1'b1;
                170: begin frame_summary("fr2"); clear_counts(); spur_bg = 1'b0; end
                192: bg_done = 1'b1;
                193: chk("lat_pre", 32'(gen_move), 32'd0);
                194: chk("lat_gen", 32'({gen_move, enemy_sel}), 32'b1000);
                214: begin
                         chk("pre_rst_sel", 32'({gen_move, enemy_sel}), 32'b1010);
                         chk("pre_rst_gens", 32'(gen_cnt), 32'd3);
                         reset = 1'b1;
                     end
                215: begin
                         chk("mid_rst_out", 32'({init, idle, gen_move, apply_move, draw, bg_draw,
                                                 overrun, timeout_err, enemy_sel}), 32'd0);
                         chk("f_mid_rst_flags", 32'({f_overrun, f_timeout_err}), 32'd0);
                         reset = 1'b0; in_chk = 1'b0;
                     end
                216: chk("post_rst_rst", 32'({init, idle, gen_move, apply_move, draw, bg_draw}), 32'd0);
                217: chk("post_rst_init", 32'({init, idle}), 32'b10);
                default: ;
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
